// File: rtl/alu_pkg.sv
// Shared constants for the ALU execution unit and the ALU controller:
// 4-bit operation codes, FSM state type and a shift-op classifier.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_EQUAL = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b1001;
    localparam logic [3:0] ALU_SRL   = 4'b1010;
    localparam logic [3:0] ALU_SRA   = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } alu_state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations. Shift codes and unassigned codes yield 0;
// shifts are sequenced bit-serially by the execution unit instead.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    // Decode the operation; add/sub wrap naturally at WIDTH bits.
    always_comb begin
        result = '0;
        case (op)
            ALU_AND:   result = a & b;
            ALU_SUB:   result = a - b;
            ALU_ADD:   result = a + b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_EQUAL: result = {{(WIDTH-1){1'b0}}, (a == b)};
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: accepts one request at a time, computes single-cycle
// ops through alu_comb and runs shifts one bit per cycle, then holds the
// result until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a request (in_ready=1)
// SHIFT | shifting accumulator one bit per cycle, count = bits remaining
// DONE  | result held on ALUResult with out_valid=1 until out_ready
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult
);

    alu_state_t       state;
    logic [3:0]       op_q;
    logic [4:0]       count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] comb_result;
    logic [WIDTH-1:0] acc_shifted;

    alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
        .op     (Operation),
        .a      (SrcA),
        .b      (SrcB),
        .result (comb_result)
    );

    // One-bit step of the captured shift op; SRA replicates the sign bit.
    always_comb begin
        acc_shifted = acc;
        case (op_q)
            ALU_SLL: acc_shifted = {acc[WIDTH-2:0], 1'b0};
            ALU_SRL: acc_shifted = {1'b0, acc[WIDTH-1:1]};
            ALU_SRA: acc_shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
            default: acc_shifted = acc;
        endcase
    end

    // Control FSM and datapath; flush beats in_valid and out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= '0;
            count <= '0;
            acc   <= '0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= Operation;
                        if (is_shift_op(Operation)) begin
                            acc <= SrcA;
                            if (SrcB[4:0] == 5'd0) begin
                                state <= DONE;
                            end else begin
                                count <= SrcB[4:0];
                                state <= SHIFT;
                            end
                        end else begin
                            acc   <= comb_result;
                            state <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    acc   <= acc_shifted;
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags come straight from the state register; in_ready is
    // held low while reset is asserted so every output reads 0 in reset.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign ALUResult = out_valid ? acc : '0;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed corner cases plus randomized
// operations checked against a behavioural reference model.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       Operation;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;

    int n_cmp;
    int n_err;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: whole-operation arithmetic from the opcode table.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a - b;
            4'b0010: return a + b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: return (a == b) ? 32'd1 : 32'd0;
            4'b1001: return a << sh;
            4'b1010: return a >> sh;
            4'b1011: return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'b1001 || op == 4'b1010 || op == 4'b1011) return 1 + int'(b[4:0]);
        return 1;
    endfunction

    // One full transaction: transfer, wait for result, hold for `hold` cycles
    // with out_ready low, then accept. Garbage operands are driven while busy.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold, input bit noisy);
        logic [31:0] exp_res;
        int          exp_lat;
        int          lat;
        bit          seen;
        bit          busy_ok;
        exp_res = ref_result(op, a, b);
        exp_lat = ref_latency(op, b);
        @(negedge clk);
        chk({tag, " in_ready before"}, 64'(in_ready), 64'd1);
        Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        seen     = 1'b0;
        busy_ok  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            if (in_ready || ALUResult != '0) busy_ok = 1'b0;
            if (noisy) begin
                in_valid  = 1'($urandom_range(0, 1));
                Operation = 4'($urandom);
                SrcA      = $urandom;
                SrcB      = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, " result seen"}, 64'(seen), 64'd1);
        chk({tag, " busy outputs"}, 64'(busy_ok), 64'd1);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, 64'(ALUResult), 64'(exp_res));
        for (int i = 0; i < hold; i++) begin
            if (noisy) begin
                SrcA = $urandom; SrcB = $urandom; Operation = 4'($urandom);
            end
            @(negedge clk);
            chk({tag, " hold valid"}, 64'(out_valid), 64'd1);
            chk({tag, " hold result"}, 64'(ALUResult), 64'(exp_res));
            chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " idle in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, " idle out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " idle result"}, 64'(ALUResult), 64'd0);
    endtask

    // Watch for any stray out_valid over a window of cycles.
    task automatic expect_quiet(input string tag, input int cycles);
        bit stray;
        stray = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) stray = 1'b1;
        end
        chk(tag, 64'(stray), 64'd0);
    endtask

    localparam logic [3:0] OPS [14] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                                        4'b0101, 4'b1000, 4'b1001, 4'b1010, 4'b1011,
                                        4'b0110, 4'b0111, 4'b1100, 4'b1111};

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        Operation = '0; SrcA = '0; SrcB = '0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset result", 64'(ALUResult), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd1);

        run_op("add wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);
        run_op("slt neg", 4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);
        run_op("slt pos", 4'b0101, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("eq same", 4'b1000, 32'h0000_1234, 32'h0000_1234, 0, 1'b0);
        run_op("eq diff", 4'b1000, 32'h0000_1234, 32'h0000_1235, 0, 1'b0);
        run_op("sra 31", 4'b1011, 32'h8000_0000, 32'd31, 0, 1'b0);
        run_op("sll 0", 4'b1001, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 0, 1'b0);
        run_op("srl 1", 4'b1010, 32'h8000_0001, 32'd1, 0, 1'b0);
        run_op("sub hold", 4'b0001, 32'd10, 32'd3, 5, 1'b1);
        run_op("bad code", 4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0);

        // Flush on the fifth SHIFT cycle of an SRL by 20.
        @(negedge clk);
        Operation = 4'b1010; SrcA = 32'hF000_0000; SrcB = 32'd20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush pre valid", 64'(out_valid), 64'd0);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        chk("flush in_ready", 64'(in_ready), 64'd1);
        expect_quiet("flush no result", 30);

        // Reset in the middle of a long shift.
        Operation = 4'b1011; SrcA = 32'h8000_0000; SrcB = 32'd31; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst mid out_valid", 64'(out_valid), 64'd0);
        chk("rst mid result", 64'(ALUResult), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst release in_ready", 64'(in_ready), 64'd1);
        expect_quiet("rst no result", 40);

        run_op("after rst", 4'b0011, 32'h00FF_0000, 32'h0000_00FF, 1, 1'b0);

        for (int n = 0; n < 200; n++) begin
            op = OPS[$urandom_range(0, 13)];
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            run_op("rand", op, a, b, $urandom_range(0, 3), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-005 The block SHALL have port in_valid  input  1  request present.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port Operation  input  4  ALU operation code from the ALU controller.
REQ-008 The block SHALL have port SrcA  input  WIDTH  first operand.
REQ-009 The block SHALL have port SrcB  input  WIDTH  second operand; SrcB[4:0] is the shift amount for shifts.
REQ-010 The block SHALL have port out_valid  output  1  result available.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 The block SHALL have port ALUResult  output  WIDTH  operation result.

Function
REQ-013 Encodings SHALL be: 0000 AND, 0001 SUB, 0010 ADD, 0011 OR, 0100 XOR, 0101 SLT (signed, result 1/0), 1000 EQUAL (result 1 if SrcA==SrcB else 0), 1001 SLL, 1010 SRL, 1011 SRA.
REQ-014 Any other code SHALL be accepted and SHALL produce ALUResult = 0 with single-cycle latency.
REQ-015 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-016 States SHALL be IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 IDLE: in_valid=1 captures Operation, SrcA, SrcB (transfer); non-shift op -> DONE next cycle with result registered.
REQ-018 IDLE: shift op with amount 0 -> DONE next cycle, ALUResult = SrcA.
REQ-019 IDLE: shift op with amount s>0 -> SHIFT; internal count loaded with s; accumulator loaded with SrcA.
REQ-020 SHIFT: each cycle shifts accumulator by one bit (SLL zero-fill, SRL zero-fill, SRA sign-fill) and decrements count; when count reaches 0 after the shift, next state DONE.
REQ-021 Latency from transfer cycle to first out_valid cycle SHALL be 1 cycle for non-shift ops and 1+s cycles for shifts (s = 0..31).
REQ-022 DONE: ALUResult and out_valid SHALL hold stable until out_ready=1; out_ready=1 in DONE -> IDLE next cycle.
REQ-023 Minimum throughput SHALL be one result per 2 cycles (no overlap of accept and deliver).
REQ-024 flush=1 SHALL force IDLE next cycle from any state, discard any pending result, and take priority over in_valid and out_ready.
REQ-025 ALUResult SHALL be 0 whenever out_valid=0.
REQ-026 Operands SHALL be ignored when in_ready=0 or in_valid=0.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, count 0, accumulator 0, ALUResult 0, out_valid 0, in_ready 1 on deassertion.
REQ-028 Reset mid-SHIFT or mid-DONE SHALL discard the operation; no result is delivered after reset.

Structure
REQ-029 Package alu_pkg SHALL hold the 4-bit Operation code localparams and the state enum typedef; the ALU controller SHALL share the same constants.
REQ-030 Sub-module alu_comb SHALL implement the combinational single-cycle operations (REQ-013/014 non-shift); the shift sequencer and FSM stay in alu_exec_unit.

Verification
REQ-031 ADD 0xFFFFFFFF + 0x00000001, out_ready=1 -> out_valid one cycle after transfer, ALUResult=0x00000000.
REQ-032 SLT SrcA=0xFFFFFFFF (-1), SrcB=0x00000001 -> ALUResult=1; EQUAL 0x1234 vs 0x1234 -> 1, vs 0x1235 -> 0.
REQ-033 SRA SrcA=0x80000000, SrcB=31 -> out_valid 32 cycles after transfer, ALUResult=0xFFFFFFFF; SLL amount 0 -> 1 cycle, result=SrcA.
REQ-034 SUB 10-3 with out_ready=0 for 5 cycles -> ALUResult=7 held stable, in_ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-035 SRL amount 20, flush=1 on 5th SHIFT cycle -> IDLE next cycle, out_valid never asserted; rst_n=0 mid-SHIFT -> all outputs 0 immediately, in_ready=1 after release.
